div_ctrl_32: RTL and testbench

- Controller and arbiter that shares one 32-bit iterative divider between two requesters, e.g. integer pipe 0 and pipe 1.
- Arbitrates requests round-robin and latches operands.
- Converts signed operands to magnitudes, sequences the 1-bit-per-cycle core, applies sign fix-up and the divide-by-zero/overflow rules.
- Holds the tagged result until the owner acknowledges it.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_core_u32.sv | 62 ++++++
 rtl/div_ctrl_32.sv | 159 +++++++++++++++
 tb/tb_div_ctrl_32.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the shared 32-bit divider controller.
package div_pkg;
  localparam int W    = 32;
  localparam int ITER = 32;

  localparam logic [W-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [W-1:0] OVF_A  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/div_core_u32.sv
// Unsigned restoring divider: one quotient bit per step, MSB first, ITER steps per operation.
module div_core_u32
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o,
  output logic         last_o
);
  localparam int CW = $clog2(ITER);

  logic [2*W-1:0] pr_q, pr_d;
  logic [W-1:0]   dv_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     hi;
  logic [W-1:0]   lo;
  logic [W-1:0]   diff;

  // hi is 33 bits so a divisor above 2^31 never loses the shifted-out MSB
  always_comb begin
    hi    = pr_q[2*W-1:W-1];
    lo    = {pr_q[W-2:0], 1'b0};
    diff  = hi[W-1:0] - dv_q;
    pr_d  = pr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pr_d  = {{W{1'b0}}, dividend_i};
      cnt_d = '0;
    end else if (step_i) begin
      if (hi >= {1'b0, dv_q}) begin
        pr_d = {diff, lo[W-1:1], 1'b1};
      end else begin
        pr_d = {hi[W-1:0], lo};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    pr_q <= pr_d;
    if (load_i) begin
      dv_q <= divisor_i;
    end
  end

  assign quo_o  = pr_q[W-1:0];
  assign rem_o  = pr_q[2*W-1:W];
  assign last_o = step_i && (cnt_q == CW'(ITER - 1));
endmodule

// File: rtl/div_ctrl_32.sv
// Round-robin front end that shares one iterative divider between two requesters,
// handling operand signs, divide-by-zero and signed overflow around the unsigned core.
module div_ctrl_32
  import div_pkg::*;
#(
  parameter int W            = div_pkg::W,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         sgn0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         sgn1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         dne,
  output logic         id,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  input  logic         ack
);
  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         id_q, id_d;
  logic [W-1:0] q_q, q_d, r_q, r_d;
  logic [W-1:0] a_orig_q;
  logic         neg_q_q, neg_r_q, div0_q, ovf_q;

  logic [1:0]   gnt_c;
  logic         sel, s_sel, div0_sel, ovf_sel;
  logic [W-1:0] a_sel, b_sel;
  logic         core_last;
  logic [W-1:0] uq, ur;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    logic signed [W-1:0] sv;
    sv = $signed(v);
    return (sgn && sv < 0) ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] v, input logic neg);
    logic signed [W-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  // Grant is combinational so operands are latched in the same cycle as the pulse
  always_comb begin
    gnt_c = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  assign sel      = gnt_c[1];
  assign a_sel    = sel ? a1 : a0;
  assign b_sel    = sel ? b1 : b0;
  assign s_sel    = sel ? sgn1 : sgn0;
  assign div0_sel = (b_sel == '0);
  assign ovf_sel  = s_sel && (a_sel == OVF_A) && (b_sel == '1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (gnt_c != 2'b00) begin
          ptr_d = ~sel;
          id_d  = sel;
          if (FAST_SPECIAL && (div0_sel || ovf_sel)) begin
            state_d = DONE;
            q_d     = div0_sel ? DIV0_Q : OVF_A;
            r_d     = div0_sel ? a_sel : '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (core_last) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (div0_q) begin
          q_d = DIV0_Q;
          r_d = a_orig_q;
        end else if (ovf_q) begin
          q_d = OVF_A;
          r_d = '0;
        end else begin
          q_d = apply_sign(uq, neg_q_q);
          r_d = apply_sign(ur, neg_r_q);
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  // Sign and special-case flags captured at accept, consumed in FIX
  always_ff @(posedge clk) begin
    if (gnt_c != 2'b00) begin
      a_orig_q <= a_sel;
      neg_q_q  <= s_sel & (a_sel[W-1] ^ b_sel[W-1]);
      neg_r_q  <= s_sel & a_sel[W-1];
      div0_q   <= div0_sel;
      ovf_q    <= ovf_sel;
    end
  end

  div_core_u32 u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gnt_c != 2'b00),
    .step_i     (state_q == RUN),
    .dividend_i (mag(a_sel, s_sel)),
    .divisor_i  (mag(b_sel, s_sel)),
    .quo_o      (uq),
    .rem_o      (ur),
    .last_o     (core_last)
  );

  assign gnt  = gnt_c;
  assign busy = (state_q != IDLE);
  assign dne  = (state_q == DONE);
  assign id   = id_q;
  assign q    = q_q;
  assign r    = r_q;
endmodule

// File: tb/tb_div_ctrl_32.sv
// Bench for div_ctrl_32: directed table, arbitration/reset/hold sequences and random ops vs. an arithmetic model.
module tb_div_ctrl_32;
  logic        clk, rst, ack, ack_z;
  logic [1:0]  req, req_z;
  logic [31:0] a0, b0, a1, b1;
  logic        sgn0, sgn1;
  logic [1:0]  gnt, gnt_z;
  logic        busy, dne, id, busy_z, dne_z, id_z;
  logic [31:0] q, r, q_z, r_z;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tbl[13];
  vec_t ztbl[3];

  div_ctrl_32 #(.W(32), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .a0(a0), .b0(b0), .sgn0(sgn0),
    .a1(a1), .b1(b1), .sgn1(sgn1), .gnt(gnt), .busy(busy), .dne(dne),
    .id(id), .q(q), .r(r), .ack(ack)
  );

  div_ctrl_32 #(.W(32), .FAST_SPECIAL(1'b0)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .a0(a0), .b0(b0), .sgn0(sgn0),
    .a1(a1), .b1(b1), .sgn1(sgn1), .gnt(gnt_z), .busy(busy_z), .dne(dne_z),
    .id(id_z), .q(q_z), .r(r_z), .ack(ack_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] a, b, input logic s,
                              input logic [31:0] eq, er, input int lat, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.eq = eq; v.er = er; v.lat = lat; v.nm = nm;
    return v;
  endfunction

  // Reference: plain integer arithmetic plus the two special-case rules
  function automatic void model(input logic [31:0] a, b, input logic s,
                                output logic [31:0] eq, er, output bit sp);
    longint sa, sb;
    sp = 1'b0;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; sp = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000; er = 32'd0; sp = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int who, input logic [31:0] a, b, input logic s);
    if (who == 0) begin a0 = a; b0 = b; sgn0 = s; end
    else          begin a1 = a; b1 = b; sgn1 = s; end
  endtask

  // Called at a falling edge; returns at the falling edge after the grant cycle
  task automatic get_gnt(input logic [1:0] exp, input string nm, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (gnt != 2'b00) begin
        check({nm, " gnt"}, 64'(gnt), 64'(exp));
        t  = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s gnt: got none after 60 cycles, required %b", nm, exp);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input int who, input logic [31:0] eq, er, input int lat,
                           input int t, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (dne) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s dne: got 0 after 80 cycles, required 1", nm);
      return;
    end
    check({nm, " latency"}, 64'(cyc - t), 64'(lat));
    check({nm, " q"}, 64'(q), 64'(eq));
    check({nm, " r"}, 64'(r), 64'(er));
    check({nm, " id"}, 64'(id), 64'(who));
    check({nm, " busy"}, 64'(busy), 64'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({nm, " dne after ack"}, 64'(dne), 64'd0);
    check({nm, " busy after ack"}, 64'(busy), 64'd0);
    check({nm, " q kept"}, 64'(q), 64'(eq));
    check({nm, " r kept"}, 64'(r), 64'(er));
  endtask

  task automatic run_op(input int who, input logic [31:0] a, b, input logic s,
                        input logic [31:0] eq, er, input int lat, input bit early_ack,
                        input string nm);
    int t;
    bit ok;
    set_ops(who, a, b, s);
    req[who] = 1'b1;
    get_gnt(2'(1 << who), nm, t, ok);
    req[who] = 1'b0;
    if (ok) begin
      if (early_ack) begin
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
      finish_op(who, eq, er, lat, t, nm);
    end
  endtask

  initial begin
    int t, c;
    bit ok, sp;
    int who;
    logic s;
    logic [31:0] a, b, eq, er;

    tbl[0]  = mk(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34, "u100_7");
    tbl[1]  = mk(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, "s-7_2");
    tbl[2]  = mk(32'd10,         32'd3,          1'b0, 32'd3,          32'd1,          34, "u10_3");
    tbl[3]  = mk(32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1,  "div0u");
    tbl[4]  = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1,  "sovf");
    tbl[5]  = mk(32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          34, "smin_1");
    tbl[6]  = mk(32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          34, "umax_1");
    tbl[7]  = mk(32'd9,          32'd4,          1'b0, 32'd2,          32'd1,          34, "u9_4");
    tbl[8]  = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34, "u_no_ovf");
    tbl[9]  = mk(32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1,  "div0s");
    tbl[10] = mk(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34, "s7_-2");
    tbl[11] = mk(32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,          34, "u5_big");
    tbl[12] = mk(32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 32'd1,          32'd1,          34, "ubig_big");

    ztbl[0] = mk(32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  34, "z_div0u");
    ztbl[1] = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          34, "z_sovf");
    ztbl[2] = mk(32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  34, "z_div0s");

    rst = 1'b1; req = 2'b00; req_z = 2'b00; ack = 1'b0; ack_z = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sgn0 = 1'b0; sgn1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset gnt", 64'(gnt), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset dne", 64'(dne), 64'd0);
    check("reset id", 64'(id), 64'd0);
    check("reset q", 64'(q), 64'd0);
    check("reset r", 64'(r), 64'd0);
    check("reset busy_z", 64'(busy_z), 64'd0);
    check("reset dne_z", 64'(dne_z), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_op(i % 2, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].eq, tbl[i].er, tbl[i].lat, 1'b0, tbl[i].nm);

    // Both requesting right after reset: requester 0 first, then 1, then 0 again
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_ops(0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    set_ops(1, 32'd10, 32'd3, 1'b0);
    req = 2'b11;
    get_gnt(2'b01, "both0", t, ok);
    req[0] = 1'b0;
    if (ok) finish_op(0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, t, "both0");
    c = cyc;
    get_gnt(2'b10, "both1", t, ok);
    req[1] = 1'b0;
    check("both1 gnt cycle", 64'(t), 64'(c));
    if (ok) finish_op(1, 32'd3, 32'd1, 34, t, "both1");
    set_ops(0, 32'd100, 32'd7, 1'b0);
    set_ops(1, 32'd9, 32'd4, 1'b0);
    req = 2'b11;
    get_gnt(2'b01, "alt0", t, ok);
    req[0] = 1'b0;
    if (ok) finish_op(0, 32'd14, 32'd2, 34, t, "alt0");
    get_gnt(2'b10, "alt1", t, ok);
    req[1] = 1'b0;
    if (ok) finish_op(1, 32'd2, 32'd1, 34, t, "alt1");

    // Result held in DONE for 20 cycles with both requests pending
    set_ops(0, 32'h0000_1000, 32'h10, 1'b0);
    set_ops(1, 32'd77, 32'd5, 1'b1);
    req = 2'b11;
    get_gnt(2'b01, "hold", t, ok);
    for (int i = 0; i < 80 && !dne; i++) @(negedge clk);
    check("hold latency", 64'(cyc - t), 64'd34);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("hold gnt", 64'(gnt), 64'd0);
      check("hold dne", 64'(dne), 64'd1);
      check("hold q", 64'(q), 64'h100);
      check("hold r", 64'(r), 64'd0);
      check("hold id", 64'(id), 64'd0);
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    c = cyc;
    get_gnt(2'b10, "hold next", t, ok);
    req = 2'b00;
    check("hold next gnt cycle", 64'(t), 64'(c));
    if (ok) finish_op(1, 32'd15, 32'd2, 34, t, "hold next");

    // Reset in the middle of RUN aborts the operation and re-arms the pointer
    set_ops(0, 32'd100, 32'd7, 1'b0);
    req = 2'b01;
    get_gnt(2'b01, "rstmid", t, ok);
    req = 2'b00;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid busy", 64'(busy), 64'd0);
    check("rstmid dne", 64'(dne), 64'd0);
    check("rstmid q", 64'(q), 64'd0);
    check("rstmid r", 64'(r), 64'd0);
    check("rstmid id", 64'(id), 64'd0);
    repeat (40) @(negedge clk);
    check("rstmid no result", 64'(dne), 64'd0);
    set_ops(0, 32'd9, 32'd4, 1'b0);
    set_ops(1, 32'd20, 32'd6, 1'b0);
    req = 2'b11;
    get_gnt(2'b01, "rearm0", t, ok);
    req[0] = 1'b0;
    if (ok) finish_op(0, 32'd2, 32'd1, 34, t, "rearm0");
    get_gnt(2'b10, "rearm1", t, ok);
    req[1] = 1'b0;
    if (ok) finish_op(1, 32'd3, 32'd2, 34, t, "rearm1");

    // Special cases through the full core when the bypass is disabled
    for (int i = 0; i < 3; i++) begin
      set_ops(0, ztbl[i].a, ztbl[i].b, ztbl[i].s);
      req_z = 2'b01;
      #1;
      check({ztbl[i].nm, " gnt"}, 64'(gnt_z), 64'd1);
      t = cyc;
      @(negedge clk);
      req_z = 2'b00;
      for (int k = 0; k < 80 && !dne_z; k++) @(negedge clk);
      check({ztbl[i].nm, " latency"}, 64'(cyc - t), 64'(ztbl[i].lat));
      check({ztbl[i].nm, " q"}, 64'(q_z), 64'(ztbl[i].eq));
      check({ztbl[i].nm, " r"}, 64'(r_z), 64'(ztbl[i].er));
      check({ztbl[i].nm, " id"}, 64'(id_z), 64'd0);
      ack_z = 1'b1;
      @(negedge clk);
      ack_z = 1'b0;
      check({ztbl[i].nm, " dne after ack"}, 64'(dne_z), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      who = int'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      model(a, b, s, eq, er, sp);
      run_op(who, a, b, s, eq, er, sp ? 1 : 34, !sp && (i % 3 == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
